// File: rtl/load_scoreboard.sv
// load_scoreboard: tracks destination registers of in-flight loads between ID
// issue and data return. It raises a stall for load-use, load-WAW and full
// hazards, and rolls back loads that memory has not yet accepted when a
// mispredict flush arrives.
module load_scoreboard #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       id_valid,
    input  logic [4:0]                 id_rs1,
    input  logic [4:0]                 id_rs2,
    input  logic                       id_useRs1,
    input  logic                       id_useRs2,
    input  logic [4:0]                 id_rd,
    input  logic                       id_regWrite,
    input  logic                       id_isLoad,
    input  logic                       mem_accept,
    input  logic                       ld_done_valid,
    input  logic [4:0]                 ld_done_rd,
    input  logic                       flush,
    output logic                       stall,
    output logic [31:0]                pending_vec,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [CNT_W-1:0]           stall_cycles,
    output logic                       proto_err
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    // FIFO storage and the three wrap-bit pointers: entries between rd_ptr and
    // acc_ptr are accepted by memory, entries between acc_ptr and wr_ptr are
    // still speculative and can be squashed by a flush.
    logic [4:0]    entry_rd [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] acc_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_next;
    logic [PW-1:0] acc_ptr_next;

    logic [PW-1:0] count;
    logic          full;
    logic [31:0]   pend;
    logic [PW-1:0] slot;
    logic          hz_rs1;
    logic          hz_rs2;
    logic          hz_rd;
    logic          hz_full;
    logic          issue;
    logic          accept_ok;
    logic          pop_ok;
    logic [4:0]    head_rd;
    logic          err_set;

    assign count     = wr_ptr - rd_ptr;
    assign full      = (count == PW'(DEPTH));
    assign occupancy = count;
    assign head_rd   = entry_rd[rd_ptr[IW-1:0]];

    // Build the pending-register vector from the valid window of the FIFO;
    // x0 is never reported since it cannot carry a hazard.
    always_comb begin
        pend = '0;
        slot = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = rd_ptr + PW'(k);
            if (PW'(k) < count) begin
                pend[entry_rd[slot[IW-1:0]]] = 1'b1;
            end
        end
        pend[0] = 1'b0;
    end

    assign pending_vec = pend;

    // Hazard detection uses only registered scoreboard state, so a return or
    // accept in the same cycle never releases the stall early.
    always_comb begin
        hz_rs1  = id_useRs1 && (id_rs1 != 5'd0) && pend[id_rs1];
        hz_rs2  = id_useRs2 && (id_rs2 != 5'd0) && pend[id_rs2];
        hz_rd   = id_regWrite && (id_rd != 5'd0) && pend[id_rd];
        hz_full = id_isLoad && full;
        stall   = id_valid && (hz_rs1 || hz_rs2 || hz_rd || hz_full);
    end

    // Decide this cycle's pointer movements and whether the memory side broke
    // the in-order protocol. A flush pulls wr_ptr back to the post-accept
    // acc_ptr, discarding any same-cycle issue.
    always_comb begin
        issue        = id_valid && !stall && id_isLoad && id_regWrite &&
                       (id_rd != 5'd0) && !flush;
        accept_ok    = mem_accept && (acc_ptr != wr_ptr);
        pop_ok       = ld_done_valid && (rd_ptr != acc_ptr);
        acc_ptr_next = acc_ptr + PW'(accept_ok);
        wr_ptr_next  = wr_ptr;
        if (flush) begin
            wr_ptr_next = acc_ptr_next;
        end else if (issue) begin
            wr_ptr_next = wr_ptr + PW'(1);
        end
        err_set = (mem_accept && !accept_ok) ||
                  (ld_done_valid && !pop_ok) ||
                  (pop_ok && (ld_done_rd != head_rd));
    end

    // Pointer registers and entry writes; reset empties the FIFO at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            acc_ptr <= '0;
            rd_ptr  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_rd[i] <= 5'd0;
            end
        end else begin
            wr_ptr  <= wr_ptr_next;
            acc_ptr <= acc_ptr_next;
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (issue) begin
                entry_rd[wr_ptr[IW-1:0]] <= id_rd;
            end
        end
    end

    // Saturating count of stalled cycles for performance monitoring.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    // Sticky protocol error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err <= 1'b0;
        end else if (err_set) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_load_scoreboard.sv
// tb_load_scoreboard: table-driven directed sequences, hand-written corner
// cases and randomized traffic checked against a queue-based reference model.
module tb_load_scoreboard;

    localparam int DEPTH  = 4;
    localparam int CNT_W  = 4;
    localparam int SATMAX = (1 << CNT_W) - 1;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_useRs1;
    logic        id_useRs2;
    logic [4:0]  id_rd;
    logic        id_regWrite;
    logic        id_isLoad;
    logic        mem_accept;
    logic        ld_done_valid;
    logic [4:0]  ld_done_rd;
    logic        flush;
    logic        stall;
    logic [31:0] pending_vec;
    logic [2:0]  occupancy;
    logic [CNT_W-1:0] stall_cycles;
    logic        proto_err;

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic       acc;
        logic       done;
        logic [4:0] drd;
        logic       fl;
        logic        eStall;
        int          eOcc;
        logic [31:0] ePend;
        logic        ePerr;
        int          eScnt;
    } vec_t;

    vec_t tbl[$];

    int total = 0;
    int bad   = 0;

    int mq[$];
    int nacc;
    bit mPerr;
    int mScnt;

    load_scoreboard #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_useRs1     (id_useRs1),
        .id_useRs2     (id_useRs2),
        .id_rd         (id_rd),
        .id_regWrite   (id_regWrite),
        .id_isLoad     (id_isLoad),
        .mem_accept    (mem_accept),
        .ld_done_valid (ld_done_valid),
        .ld_done_rd    (ld_done_rd),
        .flush         (flush),
        .stall         (stall),
        .pending_vec   (pending_vec),
        .occupancy     (occupancy),
        .stall_cycles  (stall_cycles),
        .proto_err     (proto_err)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t vecIn(logic v, logic ld, logic [4:0] rd, logic u1,
                                   logic [4:0] rs1, logic acc, logic done,
                                   logic [4:0] drd, logic fl);
        vec_t t;
        t = '{default: 0};
        t.v = v;  t.ld = ld;  t.rd = rd;  t.rw = v;
        t.u1 = u1; t.rs1 = rs1;
        t.acc = acc; t.done = done; t.drd = drd; t.fl = fl;
        return t;
    endfunction

    task automatic addVec(vec_t t, logic st, int occ, logic [31:0] pend,
                          logic perr, int scnt);
        t.eStall = st; t.eOcc = occ; t.ePend = pend; t.ePerr = perr; t.eScnt = scnt;
        tbl.push_back(t);
    endtask

    task automatic driveInputs(vec_t t);
        id_valid = t.v;   id_rs1 = t.rs1;  id_rs2 = t.rs2;
        id_useRs1 = t.u1; id_useRs2 = t.u2;
        id_rd = t.rd;     id_regWrite = t.rw; id_isLoad = t.ld;
        mem_accept = t.acc; ld_done_valid = t.done; ld_done_rd = t.drd;
        flush = t.fl;
    endtask

    task automatic applyStimulus(vec_t t);
        @(negedge clk);
        driveInputs(t);
        #1;
    endtask

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit modelPending(int r);
        if (r == 0) return 1'b0;
        foreach (mq[i]) if (mq[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] modelPendVec();
        logic [31:0] p;
        p = '0;
        for (int r = 1; r < 32; r++) p[r] = modelPending(r);
        return p;
    endfunction

    function automatic bit modelStall();
        bit h;
        h = (id_useRs1 && modelPending(int'(id_rs1))) ||
            (id_useRs2 && modelPending(int'(id_rs2))) ||
            (id_regWrite && modelPending(int'(id_rd))) ||
            (id_isLoad && (mq.size() == DEPTH));
        return id_valid && h;
    endfunction

    task automatic modelReset();
        mq.delete();
        nacc  = 0;
        mPerr = 1'b0;
        mScnt = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic modelStep();
        bit st, accOk, popOk, iss;
        st    = modelStall();
        accOk = mem_accept && (nacc < mq.size());
        popOk = ld_done_valid && (nacc > 0);
        iss   = id_valid && !st && id_isLoad && id_regWrite && (id_rd != 0) && !flush;
        if (mem_accept && !accOk) mPerr = 1'b1;
        if (ld_done_valid && !popOk) mPerr = 1'b1;
        if (popOk) begin
            if (mq[0] != int'(ld_done_rd)) mPerr = 1'b1;
            void'(mq.pop_front());
            nacc--;
        end
        if (accOk) nacc++;
        if (flush) begin
            while (mq.size() > nacc) void'(mq.pop_back());
        end else if (iss) begin
            mq.push_back(int'(id_rd));
        end
        if (st && mScnt < SATMAX) mScnt++;
    endtask

    task automatic checkModel(string tag);
        checkOutput({tag, ".stall"}, 32'(stall), 32'(modelStall()));
        checkOutput({tag, ".pend"}, pending_vec, modelPendVec());
        checkOutput({tag, ".occ"}, 32'(occupancy), 32'(mq.size()));
        checkOutput({tag, ".scnt"}, 32'(stall_cycles), 32'(mScnt));
        checkOutput({tag, ".perr"}, 32'(proto_err), 32'(mPerr));
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        driveInputs(vecIn(0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        checkOutput("rst.occ", 32'(occupancy), 32'd0);
        checkOutput("rst.pend", pending_vec, 32'd0);
        checkOutput("rst.scnt", 32'(stall_cycles), 32'd0);
        checkOutput("rst.perr", 32'(proto_err), 32'd0);
        checkOutput("rst.stall", 32'(stall), 32'd0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t t;
        vec_t idle;
        rst_n = 1'b0;
        idle  = vecIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
        driveInputs(idle);
        modelReset();

        // load-use on x5, load to x0
        addVec(vecIn(1, 1, 5, 0, 0, 0, 0, 0, 0),  0, 0, 32'h0,   0, 0);
        addVec(vecIn(1, 0, 10, 1, 5, 1, 0, 0, 0), 1, 1, 32'h20,  0, 0);
        addVec(vecIn(1, 0, 10, 1, 5, 0, 0, 0, 0), 1, 1, 32'h20,  0, 1);
        addVec(vecIn(1, 0, 10, 1, 5, 0, 1, 5, 0), 1, 1, 32'h20,  0, 2);
        addVec(vecIn(1, 0, 10, 1, 5, 0, 0, 0, 0), 0, 0, 32'h0,   0, 3);
        addVec(vecIn(1, 1, 0, 0, 0, 0, 0, 0, 0),  0, 0, 32'h0,   0, 3);
        addVec(vecIn(1, 0, 10, 1, 0, 0, 0, 0, 0), 0, 0, 32'h0,   0, 3);
        // fill to DEPTH, fifth load stalls on full
        addVec(vecIn(1, 1, 1, 0, 0, 0, 0, 0, 0),  0, 0, 32'h0,   0, 3);
        addVec(vecIn(1, 1, 2, 0, 0, 0, 0, 0, 0),  0, 1, 32'h2,   0, 3);
        addVec(vecIn(1, 1, 3, 0, 0, 0, 0, 0, 0),  0, 2, 32'h6,   0, 3);
        addVec(vecIn(1, 1, 4, 0, 0, 0, 0, 0, 0),  0, 3, 32'hE,   0, 3);
        addVec(vecIn(1, 1, 8, 0, 0, 1, 0, 0, 0),  1, 4, 32'h1E,  0, 3);
        addVec(vecIn(1, 1, 8, 0, 0, 1, 1, 1, 0),  1, 4, 32'h1E,  0, 4);
        addVec(vecIn(1, 1, 8, 0, 0, 0, 0, 0, 0),  0, 3, 32'h1C,  0, 5);
        addVec(vecIn(0, 0, 0, 0, 0, 0, 1, 2, 0),  0, 4, 32'h11C, 0, 5);
        addVec(vecIn(0, 0, 0, 0, 0, 1, 0, 0, 0),  0, 3, 32'h118, 0, 5);
        addVec(vecIn(0, 0, 0, 0, 0, 1, 1, 3, 0),  0, 3, 32'h118, 0, 5);
        addVec(vecIn(0, 0, 0, 0, 0, 1, 1, 4, 0),  0, 2, 32'h110, 0, 5);
        addVec(vecIn(0, 0, 0, 0, 0, 0, 1, 8, 0),  0, 1, 32'h100, 0, 5);
        addVec(idle,                              0, 0, 32'h0,   0, 5);
        // flush keeps only the accepted x6
        addVec(vecIn(1, 1, 6, 0, 0, 0, 0, 0, 0),  0, 0, 32'h0,   0, 5);
        addVec(vecIn(1, 1, 7, 0, 0, 1, 0, 0, 0),  0, 1, 32'h40,  0, 5);
        addVec(vecIn(0, 0, 0, 0, 0, 0, 0, 0, 1),  0, 2, 32'hC0,  0, 5);
        addVec(idle,                              0, 1, 32'h40,  0, 5);
        addVec(vecIn(0, 0, 0, 0, 0, 0, 1, 6, 0),  0, 1, 32'h40,  0, 5);
        addVec(idle,                              0, 0, 32'h0,   0, 5);
        // flush with coincident accept of x7 and issue of x8
        addVec(vecIn(1, 1, 6, 0, 0, 0, 0, 0, 0),  0, 0, 32'h0,   0, 5);
        addVec(vecIn(1, 1, 7, 0, 0, 1, 0, 0, 0),  0, 1, 32'h40,  0, 5);
        addVec(vecIn(1, 1, 8, 0, 0, 1, 0, 0, 1),  0, 2, 32'hC0,  0, 5);
        addVec(idle,                              0, 2, 32'hC0,  0, 5);
        addVec(vecIn(0, 0, 0, 0, 0, 0, 1, 6, 0),  0, 2, 32'hC0,  0, 5);
        addVec(vecIn(0, 0, 0, 0, 0, 0, 1, 7, 0),  0, 1, 32'h80,  0, 5);
        addVec(idle,                              0, 0, 32'h0,   0, 5);
        // rd mismatch pops and sets the sticky error, then empty return
        addVec(vecIn(1, 1, 3, 0, 0, 0, 0, 0, 0),  0, 0, 32'h0,   0, 5);
        addVec(vecIn(0, 0, 0, 0, 0, 1, 0, 0, 0),  0, 1, 32'h8,   0, 5);
        addVec(vecIn(0, 0, 0, 0, 0, 0, 1, 9, 0),  0, 1, 32'h8,   0, 5);
        addVec(idle,                              0, 0, 32'h0,   1, 5);
        addVec(vecIn(0, 0, 0, 0, 0, 0, 1, 0, 0),  0, 0, 32'h0,   1, 5);
        addVec(idle,                              0, 0, 32'h0,   1, 5);

        doReset();
        for (int i = 0; i < tbl.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            applyStimulus(tbl[i]);
            checkOutput({tag, ".stall"}, 32'(stall), 32'(tbl[i].eStall));
            checkOutput({tag, ".occ"}, 32'(occupancy), 32'(tbl[i].eOcc));
            checkOutput({tag, ".pend"}, pending_vec, tbl[i].ePend);
            checkOutput({tag, ".perr"}, 32'(proto_err), 32'(tbl[i].ePerr));
            checkOutput({tag, ".scnt"}, 32'(stall_cycles), 32'(tbl[i].eScnt));
            modelStep();
        end

        // reset in the middle of traffic drops entries and clears sticky state
        applyStimulus(vecIn(1, 1, 1, 0, 0, 0, 0, 0, 0));
        modelStep();
        applyStimulus(vecIn(1, 1, 2, 0, 0, 1, 0, 0, 0));
        modelStep();
        @(negedge clk);
        rst_n = 1'b0;
        t = vecIn(1, 0, 9, 1, 1, 0, 0, 0, 0);
        driveInputs(t);
        #1;
        checkOutput("midrst.occ", 32'(occupancy), 32'd0);
        checkOutput("midrst.pend", pending_vec, 32'd0);
        checkOutput("midrst.perr", 32'(proto_err), 32'd0);
        checkOutput("midrst.scnt", 32'(stall_cycles), 32'd0);
        checkOutput("midrst.stall", 32'(stall), 32'd0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        driveInputs(idle);

        // spurious accept on an empty scoreboard
        applyStimulus(vecIn(0, 0, 0, 0, 0, 1, 0, 0, 0));
        modelStep();
        applyStimulus(idle);
        checkOutput("spurAcc.perr", 32'(proto_err), 32'd1);
        modelStep();

        // return with nothing accepted (one load issued but not accepted)
        doReset();
        applyStimulus(vecIn(1, 1, 4, 0, 0, 0, 0, 0, 0));
        modelStep();
        applyStimulus(vecIn(0, 0, 0, 0, 0, 0, 1, 4, 0));
        modelStep();
        applyStimulus(idle);
        checkOutput("unaccDone.perr", 32'(proto_err), 32'd1);
        checkOutput("unaccDone.occ", 32'(occupancy), 32'd1);
        modelStep();

        // stall counter saturation
        doReset();
        applyStimulus(vecIn(1, 1, 5, 0, 0, 0, 0, 0, 0));
        modelStep();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecIn(1, 0, 10, 1, 5, 0, 0, 0, 0));
            modelStep();
        end
        applyStimulus(vecIn(1, 0, 10, 1, 5, 0, 0, 0, 0));
        checkOutput("sat.scnt", 32'(stall_cycles), 32'(SATMAX));
        checkOutput("sat.stall", 32'(stall), 32'd1);
        modelStep();

        // randomized traffic against the reference model
        for (int seg = 0; seg < 4; seg++) begin
            doReset();
            for (int c = 0; c < 500; c++) begin
                t = '{default: 0};
                t.v    = ($urandom % 4) != 0;
                t.rs1  = 5'($urandom % 8);
                t.rs2  = 5'($urandom % 8);
                t.rd   = 5'($urandom % 8);
                t.u1   = 1'($urandom % 2);
                t.u2   = 1'($urandom % 2);
                t.rw   = ($urandom % 4) != 0;
                t.ld   = 1'($urandom % 2);
                t.acc  = (mq.size() > nacc) ? 1'($urandom % 2) : (($urandom % 20) == 0);
                t.done = (nacc > 0) ? (($urandom % 3) == 0) : (($urandom % 20) == 0);
                if ((mq.size() > 0) && (($urandom % 16) != 0))
                    t.drd = 5'(mq[0]);
                else
                    t.drd = 5'($urandom % 32);
                t.fl   = ($urandom % 16) == 0;
                applyStimulus(t);
                checkModel($sformatf("rnd%0d_%0d", seg, c));
                modelStep();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
